// File: rtl/stack_cmd_sequencer_if.sv
// Upstream request/response handshake between a client and the stack command sequencer.
`timescale 1ns/1ps
interface stack_cmd_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_cmd;
    logic [2:0] req_index;
    logic [3:0] req_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic       rsp_err;

    modport master (
        output req_valid, req_cmd, req_index, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_cmd, req_index, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/stack_cmd_sequencer.sv
// Turns upstream PUSH/POP/GET requests into single-cycle stack commands, tracks the
// stack level locally and rejects requests that would over/underflow the stack.
`timescale 1ns/1ps
module stack_cmd_sequencer #(
    parameter int DEPTH = 5
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    stack_cmd_sequencer_if.slave bus,
    output logic [1:0]           o_command,
    output logic [2:0]           o_index,
    inout  wire  [3:0]           io_data,
    output logic [2:0]           o_level
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [1:0] CMD_NOP  = 2'b00;
    localparam logic [1:0] CMD_PUSH = 2'b01;
    localparam logic [1:0] CMD_POP  = 2'b10;
    localparam logic [1:0] CMD_GET  = 2'b11;
    localparam logic [2:0] LVL_FULL = 3'(DEPTH);

    state_t     r_state, w_state_next;
    logic [1:0] r_cmd, w_cmd_next;
    logic [2:0] r_index, w_index_next;
    logic [3:0] r_data, w_data_next;
    logic [2:0] r_level, w_level_next;
    logic [3:0] r_rsp_data, w_rsp_data_next;
    logic       r_rsp_err, w_rsp_err_next;
    logic       r_started;
    logic       w_req_err;

    always_comb begin
        unique case (bus.req_cmd)
            CMD_PUSH: w_req_err = (r_level == LVL_FULL);
            CMD_POP:  w_req_err = (r_level == 3'd0);
            CMD_GET:  w_req_err = (bus.req_index >= r_level);
            default:  w_req_err = 1'b0;
        endcase
    end

    // r_started keeps the sequencer from accepting until one edge after reset release
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_cmd      <= CMD_NOP;
            r_index    <= 3'd0;
            r_data     <= 4'd0;
            r_level    <= 3'd0;
            r_rsp_data <= 4'd0;
            r_rsp_err  <= 1'b0;
            r_started  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cmd      <= w_cmd_next;
            r_index    <= w_index_next;
            r_data     <= w_data_next;
            r_level    <= w_level_next;
            r_rsp_data <= w_rsp_data_next;
            r_rsp_err  <= w_rsp_err_next;
            r_started  <= 1'b1;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_cmd_next      = r_cmd;
        w_index_next    = r_index;
        w_data_next     = r_data;
        w_level_next    = r_level;
        w_rsp_data_next = r_rsp_data;
        w_rsp_err_next  = r_rsp_err;
        unique case (r_state)
            IDLE: begin
                if (r_started && bus.req_valid) begin
                    w_cmd_next      = bus.req_cmd;
                    w_index_next    = bus.req_index;
                    w_data_next     = bus.req_data;
                    w_rsp_data_next = 4'd0;
                    w_rsp_err_next  = w_req_err;
                    // NOPs and rejected requests answer immediately without touching the stack
                    if (bus.req_cmd == CMD_NOP || w_req_err)
                        w_state_next = RESP;
                    else
                        w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                w_state_next = WAIT;
                if (r_cmd == CMD_PUSH)
                    w_level_next = r_level + 3'd1;
                else if (r_cmd == CMD_POP)
                    w_level_next = r_level - 3'd1;
            end
            WAIT: begin
                w_state_next = RESP;
                if (r_cmd == CMD_POP || r_cmd == CMD_GET)
                    w_rsp_data_next = io_data;
                else
                    w_rsp_data_next = 4'd0;
            end
            RESP: begin
                if (bus.rsp_ready)
                    w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign bus.req_ready = (r_state == IDLE) && r_started;
    assign bus.rsp_valid = (r_state == RESP);
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign o_command     = (r_state == ISSUE) ? r_cmd : CMD_NOP;
    assign o_index       = (r_state == ISSUE) ? r_index : 3'd0;
    assign o_level       = r_level;
    assign io_data       = (r_state == ISSUE && r_cmd == CMD_PUSH) ? r_data : 4'bzzzz;
endmodule

// File: tb/tb_stack_cmd_sequencer.sv
// Directed bench: a small behavioural stack sits on the shared bus, client requests are checked against hand-computed results.
`timescale 1ns/1ps
module tb_stack_cmd_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stack_cmd_sequencer_if bus();
    logic [1:0] command;
    logic [2:0] index;
    logic [2:0] level;
    wire  [3:0] io_data;

    logic       drive_en;
    logic [3:0] drive_val;
    assign io_data = drive_en ? drive_val : 4'bzzzz;
    // undriven bus reads as zero in every simulator
    pulldown pd0 (io_data[0]);
    pulldown pd1 (io_data[1]);
    pulldown pd2 (io_data[2]);
    pulldown pd3 (io_data[3]);

    stack_cmd_sequencer #(.DEPTH(5)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .bus      (bus.slave),
        .o_command(command),
        .o_index  (index),
        .io_data  (io_data),
        .o_level  (level)
    );

    // Behavioural stack: reacts to the command seen on an edge, answers during the following cycle
    logic [3:0] mem [8];
    int sp;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp        <= 0;
            drive_en  <= 1'b0;
            drive_val <= 4'd0;
        end else begin
            drive_en <= 1'b0;
            case (command)
                2'b01: begin mem[3'(sp)] <= io_data; sp <= sp + 1; end
                2'b10: begin drive_en <= 1'b1; drive_val <= mem[3'(sp - 1)]; sp <= sp - 1; end
                2'b11: begin drive_en <= 1'b1; drive_val <= mem[3'(sp - 1 - int'(index))]; end
                default: ;
            endcase
        end
    end

    int issue_cnt = 0;
    int io_cnt = 0;
    logic [1:0] issue_cmd;
    logic [2:0] issue_idx;
    logic [3:0] issue_io;
    always @(negedge clk) begin
        if (command != 2'b00) begin
            issue_cnt++;
            issue_cmd = command;
            issue_idx = index;
            issue_io  = io_data;
        end
        if (!drive_en && io_data != 4'h0) io_cnt++;
    end

    int compared = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic xact(input string tag, input logic [1:0] cmd, input logic [2:0] idx,
                        input logic [3:0] data, input logic early_rdy, input int hold,
                        input logic [3:0] exp_data, input logic exp_err, input int exp_lat,
                        input int exp_issue);
        int lat;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_cmd   = cmd;
        bus.req_index = idx;
        bus.req_data  = data;
        bus.rsp_ready = early_rdy;
        check({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        issue_cnt = 0;
        io_cnt = 0;
        lat = 0;
        while (!bus.rsp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " rsp_data"}, 32'(bus.rsp_data), 32'(exp_data));
        check({tag, " rsp_err"}, 32'(bus.rsp_err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            bus.req_valid = 1'b1;
            bus.req_cmd   = 2'b01;
            @(posedge clk); #1;
            check({tag, " hold rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
            check({tag, " hold rsp_data"}, 32'(bus.rsp_data), 32'(exp_data));
            check({tag, " hold req_ready"}, 32'(bus.req_ready), 32'd0);
            check({tag, " hold level"}, 32'(level), 32'd5);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check({tag, " rsp_valid after take"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, " issue count"}, 32'(issue_cnt), 32'(exp_issue));
        check({tag, " io drive count"}, 32'(io_cnt), (cmd == 2'b01 && exp_issue == 1) ? 32'd1 : 32'd0);
        if (exp_issue == 1) begin
            check({tag, " issued cmd"}, 32'(issue_cmd), 32'(cmd));
            check({tag, " issued index"}, 32'(issue_idx), 32'(idx));
            check({tag, " issued io"}, 32'(issue_io), (cmd == 2'b01) ? 32'(data) : 32'd0);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_cmd   = 2'b00;
        bus.req_index = 3'd0;
        bus.req_data  = 4'd0;
        bus.rsp_ready = 1'b0;
        #1;
        check("reset req_ready", 32'(bus.req_ready), 32'd0);
        check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset rsp_data", 32'(bus.rsp_data), 32'd0);
        check("reset rsp_err", 32'(bus.rsp_err), 32'd0);
        check("reset command", 32'(command), 32'd0);
        check("reset index", 32'(index), 32'd0);
        check("reset io_data", 32'(io_data), 32'd0);
        check("reset level", 32'(level), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("pre-edge req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        check("post-release req_ready", 32'(bus.req_ready), 32'd1);

        xact("push3", 2'b01, 3'd0, 4'h3, 1'b0, 0, 4'h0, 1'b0, 2, 1);
        xact("push7", 2'b01, 3'd0, 4'h7, 1'b0, 0, 4'h0, 1'b0, 2, 1);
        xact("push9", 2'b01, 3'd0, 4'h9, 1'b0, 0, 4'h0, 1'b0, 2, 1);
        check("level after 3 pushes", 32'(level), 32'd3);

        xact("get0", 2'b11, 3'd0, 4'h0, 1'b0, 0, 4'h9, 1'b0, 2, 1);
        xact("get2", 2'b11, 3'd2, 4'h0, 1'b1, 0, 4'h3, 1'b0, 2, 1);
        xact("get3 err", 2'b11, 3'd3, 4'h0, 1'b0, 0, 4'h0, 1'b1, 0, 0);
        check("level after gets", 32'(level), 32'd3);

        xact("pop1", 2'b10, 3'd0, 4'h0, 1'b0, 0, 4'h9, 1'b0, 2, 1);
        xact("pop2", 2'b10, 3'd0, 4'h0, 1'b0, 0, 4'h7, 1'b0, 2, 1);
        xact("pop3", 2'b10, 3'd0, 4'h0, 1'b0, 0, 4'h3, 1'b0, 2, 1);
        check("level after pops", 32'(level), 32'd0);
        xact("pop empty err", 2'b10, 3'd0, 4'h0, 1'b0, 0, 4'h0, 1'b1, 0, 0);
        xact("nop", 2'b00, 3'd0, 4'h0, 1'b0, 0, 4'h0, 1'b0, 0, 0);

        xact("fill1", 2'b01, 3'd0, 4'h1, 1'b1, 0, 4'h0, 1'b0, 2, 1);
        xact("fill2", 2'b01, 3'd0, 4'h2, 1'b0, 0, 4'h0, 1'b0, 2, 1);
        xact("fill3", 2'b01, 3'd0, 4'h3, 1'b1, 0, 4'h0, 1'b0, 2, 1);
        xact("fill4", 2'b01, 3'd0, 4'h4, 1'b0, 0, 4'h0, 1'b0, 2, 1);
        xact("fill5", 2'b01, 3'd0, 4'h5, 1'b0, 0, 4'h0, 1'b0, 2, 1);
        check("level full", 32'(level), 32'd5);
        xact("push full err", 2'b01, 3'd0, 4'hF, 1'b0, 0, 4'h0, 1'b1, 0, 0);
        check("level still full", 32'(level), 32'd5);

        xact("get4 held", 2'b11, 3'd4, 4'h0, 1'b0, 10, 4'h1, 1'b0, 2, 1);

        // Reset while a POP sits in WAIT
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_cmd   = 2'b10;
        bus.req_index = 3'd0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        check("mid-pop level", 32'(level), 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("abort rsp_data", 32'(bus.rsp_data), 32'd0);
        check("abort rsp_err", 32'(bus.rsp_err), 32'd0);
        check("abort level", 32'(level), 32'd0);
        check("abort command", 32'(command), 32'd0);
        check("abort index", 32'(index), 32'd0);
        check("abort io_data", 32'(io_data), 32'd0);
        check("abort req_ready", 32'(bus.req_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("in reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        end
        rst_n = 1'b1;
        #1;
        check("abort pre-edge req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        check("abort post-release req_ready", 32'(bus.req_ready), 32'd1);
        check("abort post-release rsp_valid", 32'(bus.rsp_valid), 32'd0);

        xact("pop after abort err", 2'b10, 3'd0, 4'h0, 1'b0, 0, 4'h0, 1'b1, 0, 0);
        xact("get after abort err", 2'b11, 3'd0, 4'h0, 1'b0, 0, 4'h0, 1'b1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
